// File: rtl/alu_share_arbiter_if.sv
// Requester-side bus of alu_share_arbiter: two packed request channels and two response channels.
// Requester r occupies bits [r*DATA_W +: DATA_W] of the operand buses and [r*ALUC_W +: ALUC_W] of aluc.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ALUC_W = 5
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*DATA_W-1:0] req_a;
  logic [2*DATA_W-1:0] req_b;
  logic [2*ALUC_W-1:0] req_aluc;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_c;
  logic                rsp_branch;
  logic [1:0]          rsp_branch2;

  modport master (
    output req_valid, req_a, req_b, req_aluc, rsp_ready,
    input  req_ready, rsp_valid, rsp_c, rsp_branch, rsp_branch2
  );

  modport slave (
    input  req_valid, req_a, req_b, req_aluc, rsp_ready,
    output req_ready, rsp_valid, rsp_c, rsp_branch, rsp_branch2
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two requesters: IDLE grants and latches operands,
// EXEC drives the ALU for one cycle and captures its result, RESP holds the result until taken.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int ALUC_W = 5,
  parameter bit RR_EN  = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  alu_share_arbiter_if.slave bus,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [ALUC_W-1:0] alu_aluc_o,
  input  logic [DATA_W-1:0] alu_c_i,
  input  logic              alu_branch_i,
  input  logic [1:0]        alu_branch2_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  op_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              prio_q, prio_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [ALUC_W-1:0] aluc_q, aluc_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic              br_q, br_d;
  logic [1:0]        br2_q, br2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              winner;

  // With both requesters valid the tie goes to the priority pointer, or to req 0 when fixed.
  always_comb begin
    if (&bus.req_valid) winner = RR_EN ? prio_q : 1'b0;
    else                winner = bus.req_valid[1];
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can infer a latch.
    state_d       = state_q;
    owner_d       = owner_q;
    prio_d        = prio_q;
    a_d           = a_q;
    b_d           = b_q;
    aluc_d        = aluc_q;
    c_d           = c_q;
    br_d          = br_q;
    br2_d         = br2_q;
    cnt_d         = cnt_q;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;

    unique case (state_q)
      ST_IDLE: begin
        // No grant is offered while reset is held, even though the state already reads IDLE.
        if (rst_ni && (|bus.req_valid)) begin
          bus.req_ready[winner] = 1'b1;
          a_d     = winner ? bus.req_a[DATA_W +: DATA_W]    : bus.req_a[0 +: DATA_W];
          b_d     = winner ? bus.req_b[DATA_W +: DATA_W]    : bus.req_b[0 +: DATA_W];
          aluc_d  = winner ? bus.req_aluc[ALUC_W +: ALUC_W] : bus.req_aluc[0 +: ALUC_W];
          owner_d = winner;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        c_d     = alu_c_i;
        br_d    = alu_branch_i;
        br2_d   = alu_branch2_i;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid[owner_q] = 1'b1;
        if (bus.rsp_ready[owner_q]) begin
          cnt_d   = cnt_q + CNT_W'(1);
          prio_d  = ~owner_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      aluc_q  <= '0;
      c_q     <= '0;
      br_q    <= 1'b0;
      br2_q   <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      a_q     <= a_d;
      b_q     <= b_d;
      aluc_q  <= aluc_d;
      c_q     <= c_d;
      br_q    <= br_d;
      br2_q   <= br2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu_a_o         = a_q;
  assign alu_b_o         = b_q;
  assign alu_aluc_o      = aluc_q;
  assign bus.rsp_c       = c_q;
  assign bus.rsp_branch  = br_q;
  assign bus.rsp_branch2 = br2_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign op_cnt_o        = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a round-robin instance (CNT_W=4) checked cycle by cycle against a
// transaction model, plus a fixed-priority instance checked against its 3-cycle service period.
module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-1:0] op;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- DUT A: round robin, 4-bit counter ----------------
  alu_share_arbiter_if #(.DATA_W(DW), .ALUC_W(AW)) ifa ();
  logic [DW-1:0] a_alu_a, a_alu_b, a_alu_c;
  logic [AW-1:0] a_aluc;
  logic          a_br, a_busy;
  logic [1:0]    a_br2;
  logic [3:0]    a_cnt;

  assign a_alu_c = a_alu_a + a_alu_b;
  assign a_br    = (a_alu_a == a_alu_b);
  assign a_br2   = {a_alu_a < a_alu_b, a_alu_a == a_alu_b};

  alu_share_arbiter #(.DATA_W(DW), .ALUC_W(AW), .RR_EN(1'b1), .CNT_W(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifa),
    .alu_a_o(a_alu_a), .alu_b_o(a_alu_b), .alu_aluc_o(a_aluc),
    .alu_c_i(a_alu_c), .alu_branch_i(a_br), .alu_branch2_i(a_br2),
    .busy_o(a_busy), .op_cnt_o(a_cnt)
  );

  // ---------------- DUT B: fixed priority, 16-bit counter ----------------
  alu_share_arbiter_if #(.DATA_W(DW), .ALUC_W(AW)) ifb ();
  logic [DW-1:0] b_alu_a, b_alu_b, b_alu_c;
  logic [AW-1:0] b_aluc;
  logic          b_br, b_busy;
  logic [1:0]    b_br2;
  logic [15:0]   b_cnt;

  assign b_alu_c = b_alu_a + b_alu_b;
  assign b_br    = (b_alu_a == b_alu_b);
  assign b_br2   = {b_alu_a < b_alu_b, b_alu_a == b_alu_b};

  alu_share_arbiter #(.DATA_W(DW), .ALUC_W(AW), .RR_EN(1'b0), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifb),
    .alu_a_o(b_alu_a), .alu_b_o(b_alu_b), .alu_aluc_o(b_aluc),
    .alu_c_i(b_alu_c), .alu_branch_i(b_br), .alu_branch2_i(b_br2),
    .busy_o(b_busy), .op_cnt_o(b_cnt)
  );

  // ---------------- reference model state for DUT A ----------------
  op_t           q0[$];
  op_t           q1[$];
  int            served[$];
  logic [1:0]    rsp_rdy_set;
  bit            m_pend;
  int            m_age;
  int            m_owner;
  int            m_ptr;
  int            m_cnt;
  logic [DW-1:0] m_c, s_c, m_a, m_b;
  logic [AW-1:0] m_op;
  logic          m_br, s_br;
  logic [1:0]    m_br2, s_br2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic op_t rand_op();
    op_t t;
    t.a  = $urandom;
    t.b  = ($urandom_range(0, 3) == 0) ? t.a : $urandom;
    t.op = AW'($urandom);
    return t;
  endfunction

  task automatic reset_model();
    q0.delete();
    q1.delete();
    m_pend = 1'b0; m_age = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    m_c = '0; s_c = '0; m_a = '0; m_b = '0; m_op = '0;
    m_br = 1'b0; s_br = 1'b0; m_br2 = 2'b00; s_br2 = 2'b00;
  endtask

  // Called at posedge+1; drives one cycle of DUT A, checks at negedge, returns at next posedge+1.
  task automatic step_a();
    logic [1:0] v, exp_ready, exp_rv;
    int   w;
    op_t  t;
    v = {q1.size() != 0, q0.size() != 0};
    ifa.req_valid = v;
    if (q0.size() != 0) begin
      ifa.req_a[31:0] = q0[0].a; ifa.req_b[31:0] = q0[0].b; ifa.req_aluc[4:0] = q0[0].op;
    end
    if (q1.size() != 0) begin
      ifa.req_a[63:32] = q1[0].a; ifa.req_b[63:32] = q1[0].b; ifa.req_aluc[9:5] = q1[0].op;
    end
    ifa.rsp_ready = rsp_rdy_set;
    @(negedge clk);
    exp_ready = 2'b00;
    w = 0;
    if (!m_pend && v != 2'b00) begin
      w = (v == 2'b11) ? m_ptr : (v[1] ? 1 : 0);
      exp_ready[w] = 1'b1;
    end
    exp_rv = (m_pend && m_age >= 2) ? (2'b01 << m_owner) : 2'b00;
    check("req_ready", ifa.req_ready, exp_ready);
    check("rsp_valid", ifa.rsp_valid, exp_rv);
    check("busy", a_busy, m_pend);
    check("op_cnt", a_cnt, m_cnt);
    check("rsp_c", ifa.rsp_c, s_c);
    check("rsp_branch", ifa.rsp_branch, s_br);
    check("rsp_branch2", ifa.rsp_branch2, s_br2);
    check("alu_a", a_alu_a, m_a);
    check("alu_b", a_alu_b, m_b);
    check("alu_aluc", a_aluc, m_op);
    if (exp_ready != 2'b00) begin
      t = (w == 0) ? q0[0] : q1[0];
      if (w == 0) q0.delete(0); else q1.delete(0);
      m_a = t.a; m_b = t.b; m_op = t.op;
      m_c = t.a + t.b; m_br = (t.a == t.b); m_br2 = {t.a < t.b, t.a == t.b};
      m_pend = 1'b1; m_age = 1; m_owner = w;
    end else if (m_pend) begin
      if (m_age >= 2 && rsp_rdy_set[m_owner]) begin
        m_pend = 1'b0;
        m_cnt  = (m_cnt + 1) % 16;
        m_ptr  = 1 - m_owner;
        served.push_back(m_owner);
      end else begin
        if (m_age == 1) begin s_c = m_c; s_br = m_br; s_br2 = m_br2; end
        m_age++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reset_model();
    ifa.req_valid = 2'b00; ifa.rsp_ready = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", a_busy, 0);
    check("rst_rsp_valid", ifa.rsp_valid, 0);
    check("rst_cnt", a_cnt, 0);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    rsp_rdy_set = 2'b11;
    for (int n = 0; n < budget && (m_pend || q0.size() != 0 || q1.size() != 0); n++) step_a();
    check("drain_left", q0.size() + q1.size() + int'(m_pend), 0);
  endtask

  initial begin
    logic [DW-1:0] ta, tb_op, sum;
    op_t o;

    ifa.req_valid = '0; ifa.req_a = '0; ifa.req_b = '0; ifa.req_aluc = '0; ifa.rsp_ready = '0;
    ifb.req_valid = '0; ifb.req_a = '0; ifb.req_b = '0; ifb.req_aluc = '0; ifb.rsp_ready = '0;
    rsp_rdy_set = 2'b00;
    reset_model();
    #1;
    check("rst_b_busy", b_busy, 0);
    check("rst_b_cnt", b_cnt, 0);
    do_reset();

    // Fixed priority: req 1 starves, req 0 served every 3 cycles.
    ifb.req_valid = 2'b11; ifb.rsp_ready = 2'b11;
    ifb.req_a[63:32] = $urandom; ifb.req_b[63:32] = $urandom;
    ta = $urandom; tb_op = $urandom;
    ifb.req_a[31:0] = ta; ifb.req_b[31:0] = tb_op;
    sum = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("fp_ready1", ifb.req_ready[1], 0);
      check("fp_ready0", ifb.req_ready[0], (i % 3 == 0));
      check("fp_rsp_valid", ifb.rsp_valid, (i % 3 == 2) ? 2'b01 : 2'b00);
      if (i % 3 == 0) sum = ta + tb_op;
      if (i % 3 == 2) check("fp_c", ifb.rsp_c, sum);
      @(posedge clk);
      #1;
      if (i % 3 == 0) begin
        ta = $urandom; tb_op = $urandom;
        ifb.req_a[31:0] = ta; ifb.req_b[31:0] = tb_op;
      end
    end
    check("fp_cnt", b_cnt, 5);
    ifb.req_valid = 2'b00;

    // Single op: A=1, B=3 -> C=4, branch=0, branch2=10.
    o.a = 32'd1; o.b = 32'd3; o.op = 5'b00001;
    q0.push_back(o);
    rsp_rdy_set = 2'b01;
    repeat (4) step_a();
    check("t1_cnt", a_cnt, 1);
    check("t1_c", ifa.rsp_c, 4);
    check("t1_branch2", ifa.rsp_branch2, 2'b10);

    // Round robin from reset with both requesters loaded: order 0,1,0,1.
    do_reset();
    served.delete();
    repeat (2) begin q0.push_back(rand_op()); q1.push_back(rand_op()); end
    rsp_rdy_set = 2'b11;
    repeat (12) step_a();
    check("rr_count", served.size(), 4);
    for (int k = 0; k < served.size(); k++) check("rr_order", served[k], k % 2);

    // Response backpressure on req 0 while req 1 waits.
    served.delete();
    q0.push_back(rand_op());
    rsp_rdy_set = 2'b10;
    step_a();
    q1.push_back(rand_op());
    repeat (6) step_a();
    rsp_rdy_set = 2'b11;
    repeat (4) step_a();
    check("bp_count", served.size(), 2);
    if (served.size() == 2) begin
      check("bp_first", served[0], 0);
      check("bp_second", served[1], 1);
    end

    // Randomized traffic with random response readiness.
    for (int n = 0; n < 80; n++) begin
      if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_op());
      if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_op());
      rsp_rdy_set = 2'($urandom);
      step_a();
    end
    drain(200);

    // Async reset during EXEC.
    q0.push_back(rand_op());
    rsp_rdy_set = 2'b01;
    step_a();
    #2 rst_n = 1'b0;
    #1;
    check("rx_rsp_valid", ifa.rsp_valid, 0);
    check("rx_busy", a_busy, 0);
    check("rx_ready", ifa.req_ready, 0);
    check("rx_cnt", a_cnt, 0);
    check("rx_alu_a", a_alu_a, 0);
    reset_model();
    ifa.req_valid = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Async reset during RESP with the response still pending.
    q0.push_back(rand_op());
    rsp_rdy_set = 2'b00;
    repeat (3) step_a();
    ifa.rsp_ready = 2'b01;
    #2 rst_n = 1'b0;
    #1;
    check("rr_rsp_valid", ifa.rsp_valid, 0);
    check("rr_busy", a_busy, 0);
    check("rr_c", ifa.rsp_c, 0);
    reset_model();
    ifa.req_valid = 2'b00; ifa.rsp_ready = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rr_cnt", a_cnt, 0);

    // Fresh op after reset: A=5, B=5.
    o.a = 32'd5; o.b = 32'd5; o.op = 5'b00010;
    q0.push_back(o);
    rsp_rdy_set = 2'b01;
    repeat (4) step_a();
    check("post_rst_c", ifa.rsp_c, 10);
    check("post_rst_branch", ifa.rsp_branch, 1);
    check("post_rst_branch2", ifa.rsp_branch2, 2'b01);
    check("post_rst_cnt", a_cnt, 1);

    // Counter wrap with a 4-bit counter.
    do_reset();
    rsp_rdy_set = 2'b01;
    for (int k = 1; k <= 17; k++) begin
      q0.push_back(rand_op());
      for (int n = 0; n < 10 && (m_pend || q0.size() != 0); n++) step_a();
      check("wrap_cnt", a_cnt, k % 16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
